// File: rtl/load_unit.sv
// Load path of the memory stage: issues word reads to the cache controller and
// returns the sign/zero-extended byte, halfword or word with its instruction packet.
package load_unit_pkg;
  localparam int unsigned PKT_PC_W = 32;

  typedef enum logic [2:0] {
    LDU_LB  = 3'd0,
    LDU_LH  = 3'd1,
    LDU_LW  = 3'd2,
    LDU_LBU = 3'd3,
    LDU_LHU = 3'd4
  } ldu_operation_t;

  typedef struct packed {
    logic [PKT_PC_W-1:0] pc;
    logic [4:0]          rd_addr;
    logic [3:0]          tag;
    logic                exception;
    logic [4:0]          exception_vector;
  } instr_packet_t;
endpackage

module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned XLEN              = 32,
  parameter logic [31:0] UNCACHED_START    = 32'h0000_8000,
  parameter logic [31:0] UNCACHED_END      = 32'h0000_FFFF,
  parameter logic [4:0]  MISALIGNED_VECTOR = 5'd4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                valid_operation_i,
  input  logic [XLEN-1:0]     load_address_i,
  input  ldu_operation_t      operation_i,
  input  instr_packet_t       instr_packet_i,
  input  logic                data_accepted_i,
  output instr_packet_t       instr_packet_o,
  output logic [XLEN-1:0]     loaded_data_o,
  output logic                data_valid_o,
  output logic                idle_o,
  input  logic                cache_ctrl_load_idle_i,
  input  logic [XLEN-1:0]     cache_ctrl_data_i,
  input  logic                cache_ctrl_data_valid_i,
  output logic                cache_ctrl_read_o,
  output logic [XLEN-1:0]     cache_ctrl_address_o,
  output logic                data_cachable_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_CACHE  = 2'd1,
    WAIT_ACCEPT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  ldu_operation_t  op_q, op_d;
  logic [1:0]      lane_q, lane_d;
  instr_packet_t   packet_q, packet_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            cachable_q, cachable_d;

  logic            misaligned_c;
  logic            in_window_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [XLEN-1:0] extracted_c;

  // Address classification of the incoming request
  always_comb begin
    misaligned_c = 1'b0;
    if ((operation_i == LDU_LH || operation_i == LDU_LHU) && load_address_i[0]) begin
      misaligned_c = 1'b1;
    end
    if (operation_i == LDU_LW && load_address_i[1:0] != 2'b00) begin
      misaligned_c = 1'b1;
    end
    in_window_c = (load_address_i >= XLEN'(UNCACHED_START)) &&
                  (load_address_i <= XLEN'(UNCACHED_END));
  end

  // Lane select and extension of the returned cache word
  always_comb begin
    byte_c      = cache_ctrl_data_i[{lane_q, 3'b000} +: 8];
    half_c      = cache_ctrl_data_i[{lane_q[1], 4'b0000} +: 16];
    extracted_c = cache_ctrl_data_i;
    case (op_q)
      LDU_LB:  extracted_c = {{(XLEN-8){byte_c[7]}}, byte_c};
      LDU_LBU: extracted_c = {{(XLEN-8){1'b0}}, byte_c};
      LDU_LH:  extracted_c = {{(XLEN-16){half_c[15]}}, half_c};
      LDU_LHU: extracted_c = {{(XLEN-16){1'b0}}, half_c};
      default: extracted_c = cache_ctrl_data_i;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    lane_d            = lane_q;
    packet_d          = packet_q;
    data_d            = data_q;
    addr_d            = addr_q;
    cachable_d        = cachable_q;
    cache_ctrl_read_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_operation_i && cache_ctrl_load_idle_i) begin
          op_d       = operation_i;
          lane_d     = load_address_i[1:0];
          packet_d   = instr_packet_i;
          cachable_d = !in_window_c;
          if (misaligned_c) begin
            // Misaligned loads never reach the cache; report the exception directly
            packet_d.exception        = 1'b1;
            packet_d.exception_vector = MISALIGNED_VECTOR;
            data_d                    = '0;
            state_d                   = WAIT_ACCEPT;
          end else begin
            cache_ctrl_read_o = 1'b1;
            addr_d            = {load_address_i[XLEN-1:2], 2'b00};
            state_d           = WAIT_CACHE;
          end
        end
      end
      WAIT_CACHE: begin
        cache_ctrl_read_o = 1'b1;
        if (cache_ctrl_data_valid_i) begin
          data_d  = extracted_c;
          state_d = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (data_accepted_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      op_q       <= LDU_LB;
      lane_q     <= 2'b00;
      packet_q   <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      cachable_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
      packet_q   <= packet_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      cachable_q <= cachable_d;
    end
  end

  assign instr_packet_o       = packet_q;
  assign loaded_data_o        = data_q;
  assign cache_ctrl_address_o = addr_q;
  assign data_cachable_o      = cachable_q;
  assign data_valid_o         = (state_q == WAIT_ACCEPT);
  assign idle_o               = (state_d == IDLE);

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: directed loads push expectations, a negedge
// monitor pops and compares on every accepted result.
module tb_load_unit;
  import load_unit_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            valid_operation_i;
  logic [31:0]     load_address_i;
  ldu_operation_t  operation_i;
  instr_packet_t   instr_packet_i;
  logic            data_accepted_i;
  instr_packet_t   instr_packet_o;
  logic [31:0]     loaded_data_o;
  logic            data_valid_o;
  logic            idle_o;
  logic            cache_ctrl_load_idle_i;
  logic [31:0]     cache_ctrl_data_i;
  logic            cache_ctrl_data_valid_i;
  logic            cache_ctrl_read_o;
  logic [31:0]     cache_ctrl_address_o;
  logic            data_cachable_o;

  load_unit dut (
    .clk_i                   (clk_i),
    .rst_n_i                 (rst_n_i),
    .valid_operation_i       (valid_operation_i),
    .load_address_i          (load_address_i),
    .operation_i             (operation_i),
    .instr_packet_i          (instr_packet_i),
    .data_accepted_i         (data_accepted_i),
    .instr_packet_o          (instr_packet_o),
    .loaded_data_o           (loaded_data_o),
    .data_valid_o            (data_valid_o),
    .idle_o                  (idle_o),
    .cache_ctrl_load_idle_i  (cache_ctrl_load_idle_i),
    .cache_ctrl_data_i       (cache_ctrl_data_i),
    .cache_ctrl_data_valid_i (cache_ctrl_data_valid_i),
    .cache_ctrl_read_o       (cache_ctrl_read_o),
    .cache_ctrl_address_o    (cache_ctrl_address_o),
    .data_cachable_o         (data_cachable_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   data;
    instr_packet_t pkt;
    logic          cach;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic instr_packet_t mk_pkt(input int id);
    instr_packet_t p;
    p.pc               = 32'h0000_0100 + 32'(id) * 32'd4;
    p.rd_addr          = 5'(id);
    p.tag              = 4'(id);
    p.exception        = 1'b0;
    p.exception_vector = 5'd0;
    return p;
  endfunction

  // Monitor: every consumed result must match the oldest expectation
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_n_i && data_valid_o && data_accepted_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("loaded_data", 64'(loaded_data_o), 64'(e.data));
        chk("instr_packet", 64'(instr_packet_o), 64'(e.pkt));
        chk("cachable", 64'(data_cachable_o), 64'(e.cach));
        chk("idle_on_accept", 64'(idle_o), 64'(1));
      end
    end
  end

  task automatic run_load(input ldu_operation_t op, input logic [31:0] addr, input int id,
                          input bit mis, input int lat, input logic [31:0] word,
                          input logic [31:0] exp_data, input logic exp_cach, input int hold);
    instr_packet_t p;
    exp_t          e;
    int            reads;
    reads  = 0;
    p      = mk_pkt(id);
    e.data = exp_data;
    e.pkt  = p;
    e.cach = exp_cach;
    if (mis) begin
      e.pkt.exception        = 1'b1;
      e.pkt.exception_vector = 5'd4;
    end
    sb.push_back(e);
    valid_operation_i = 1'b1;
    operation_i       = op;
    load_address_i    = addr;
    instr_packet_i    = p;
    @(negedge clk_i);
    chk("req_on_accept", 64'(cache_ctrl_read_o), 64'(!mis));
    if (cache_ctrl_read_o) reads++;
    tick();
    valid_operation_i = 1'b0;
    if (!mis) begin
      for (int i = 1; i <= lat; i++) begin
        if (i == lat) begin
          cache_ctrl_data_valid_i = 1'b1;
          cache_ctrl_data_i       = word;
        end
        @(negedge clk_i);
        chk("read_address", 64'(cache_ctrl_address_o), 64'({addr[31:2], 2'b00}));
        if (cache_ctrl_read_o) reads++;
        tick();
        cache_ctrl_data_valid_i = 1'b0;
      end
    end
    chk("read_cycles", 64'(reads), mis ? 64'(0) : 64'(lat + 1));
    // Stalled commit side: inputs wiggle, outputs must not
    for (int h = 0; h < hold; h++) begin
      valid_operation_i       = (h % 2 == 0);
      cache_ctrl_data_valid_i = (h % 2 != 0);
      cache_ctrl_data_i       = 32'h5555_5555;
      @(negedge clk_i);
      chk("hold_valid", 64'(data_valid_o), 64'(1));
      chk("hold_no_req", 64'(cache_ctrl_read_o), 64'(0));
      chk("hold_data", 64'(loaded_data_o), 64'(exp_data));
      chk("hold_idle", 64'(idle_o), 64'(0));
      tick();
    end
    valid_operation_i       = 1'b0;
    cache_ctrl_data_valid_i = 1'b0;
    data_accepted_i         = 1'b1;
    @(negedge clk_i);
    chk("valid_at_accept", 64'(data_valid_o), 64'(1));
    tick();
    data_accepted_i = 1'b0;
  endtask

  initial begin
    rst_n_i                 = 1'b0;
    valid_operation_i       = 1'b0;
    load_address_i          = 32'h0;
    operation_i             = LDU_LW;
    instr_packet_i          = '0;
    data_accepted_i         = 1'b0;
    cache_ctrl_load_idle_i  = 1'b1;
    cache_ctrl_data_i       = 32'h0;
    cache_ctrl_data_valid_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_valid", 64'(data_valid_o), 64'(0));
    chk("rst_read", 64'(cache_ctrl_read_o), 64'(0));
    chk("rst_data", 64'(loaded_data_o), 64'(0));
    chk("rst_addr", 64'(cache_ctrl_address_o), 64'(0));
    chk("rst_cachable", 64'(data_cachable_o), 64'(1));
    chk("rst_pkt", 64'(instr_packet_o), 64'(0));
    chk("rst_idle", 64'(idle_o), 64'(1));
    tick();

    // Cache controller busy: the request must not be taken
    cache_ctrl_load_idle_i = 1'b0;
    valid_operation_i      = 1'b1;
    operation_i            = LDU_LW;
    load_address_i         = 32'h0000_4000;
    instr_packet_i         = mk_pkt(15);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("busy_no_req", 64'(cache_ctrl_read_o), 64'(0));
      chk("busy_idle", 64'(idle_o), 64'(1));
      tick();
    end
    valid_operation_i      = 1'b0;
    cache_ctrl_load_idle_i = 1'b1;
    @(negedge clk_i);
    chk("busy_no_latch", 64'(cache_ctrl_address_o), 64'(0));
    chk("busy_no_valid", 64'(data_valid_o), 64'(0));
    tick();

    //        op       addr           id mis lat word           expected       cach hold
    run_load(LDU_LW,  32'h0000_1000, 1, 0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0);
    run_load(LDU_LB,  32'h0000_2003, 2, 0, 1, 32'h80FF_0011, 32'hFFFF_FF80, 1'b1, 0);
    run_load(LDU_LBU, 32'h0000_2003, 3, 0, 1, 32'h80FF_0011, 32'h0000_0080, 1'b1, 0);
    run_load(LDU_LH,  32'h0000_9002, 4, 0, 2, 32'h7FFF_1234, 32'h0000_7FFF, 1'b0, 0);
    run_load(LDU_LHU, 32'h0000_9000, 5, 0, 1, 32'h7FFF_1234, 32'h0000_1234, 1'b0, 5);
    run_load(LDU_LW,  32'h0000_1002, 6, 1, 0, 32'h0,         32'h0,         1'b1, 0);
    run_load(LDU_LB,  32'h0000_FFFF, 7, 0, 1, 32'h7F00_0000, 32'h0000_007F, 1'b0, 0);
    run_load(LDU_LB,  32'h0000_8000, 8, 0, 2, 32'h0000_00C3, 32'hFFFF_FFC3, 1'b0, 0);
    run_load(LDU_LBU, 32'h0000_7FFF, 9, 0, 1, 32'hAB00_0000, 32'h0000_00AB, 1'b1, 0);
    run_load(LDU_LH,  32'h0001_0000, 10, 0, 1, 32'h0000_8001, 32'hFFFF_8001, 1'b1, 0);
    run_load(LDU_LHU, 32'h0000_1001, 11, 1, 0, 32'h0,        32'h0,         1'b1, 2);

    // Reset while waiting on the cache abandons the load
    valid_operation_i = 1'b1;
    operation_i       = LDU_LW;
    load_address_i    = 32'h0000_3000;
    instr_packet_i    = mk_pkt(12);
    @(negedge clk_i);
    chk("rst_test_req", 64'(cache_ctrl_read_o), 64'(1));
    tick();
    valid_operation_i = 1'b0;
    @(negedge clk_i);
    chk("rst_test_wait", 64'(cache_ctrl_read_o), 64'(1));
    rst_n_i = 1'b0;
    tick();
    rst_n_i                 = 1'b1;
    cache_ctrl_data_valid_i = 1'b1;
    cache_ctrl_data_i       = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("abort_valid", 64'(data_valid_o), 64'(0));
      chk("abort_read", 64'(cache_ctrl_read_o), 64'(0));
      chk("abort_data", 64'(loaded_data_o), 64'(0));
      chk("abort_addr", 64'(cache_ctrl_address_o), 64'(0));
      chk("abort_cachable", 64'(data_cachable_o), 64'(1));
      chk("abort_pkt", 64'(instr_packet_o), 64'(0));
      chk("abort_idle", 64'(idle_o), 64'(1));
      tick();
      cache_ctrl_data_valid_i = 1'b0;
    end

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side memory submodule of the execution unit's memory stage; read-direction counterpart of the store path into the data cache controller.
- Accepts one load op at a time, classifies the address (cachable, misaligned) and issues a read request to the cache controller.
- Waits for the returned word, then extracts and sign- or zero-extends the byte, halfword or word.
- Holds the result and instruction packet stable until the commit side accepts it.

Parameters:
XLEN, 32, data/address width.
UNCACHED_START, 32'h0000_8000, first address of the uncachable (IO/timers/system) window, inclusive.
UNCACHED_END, 32'h0000_FFFF, last address of the uncachable window, inclusive.
MISALIGNED_VECTOR, 5'd4, exception vector written to the packet on a misaligned load.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  reset, synchronous, active-low
valid_operation_i  in  1  load request valid
load_address_i  in  XLEN  byte address
operation_i  in  ldu_operation_t  LB/LH/LW/LBU/LHU
instr_packet_i  in  instr_packet_t  packet travelling with the op
data_accepted_i  in  1  commit side consumed result
instr_packet_o  out  instr_packet_t  registered packet
loaded_data_o  out  XLEN  extended load result
data_valid_o  out  1  result valid
idle_o  out  1  unit free next cycle
cache_ctrl_load_idle_i  in  1  cache controller can take a read
cache_ctrl_data_i  in  XLEN  aligned word from cache
cache_ctrl_data_valid_i  in  1  cache_ctrl_data_i valid this cycle
cache_ctrl_read_o  out  1  read request
cache_ctrl_address_o  out  XLEN  word-aligned read address ({addr[XLEN-1:2],2'b00})
data_cachable_o  out  1  address outside uncached window

Behaviour:
- Reset (rst_n_i=0 at clock edge):
  - state=IDLE.
  - data_valid_o=0, cache_ctrl_read_o=0, loaded_data_o=0, cache_ctrl_address_o=0.
  - data_cachable_o=1; instr_packet_o cleared to 0.
  - Reset mid-operation abandons the op: no data_valid_o, and any later cache_ctrl_data_valid_i arriving in IDLE is ignored.
- FSM states: IDLE, WAIT_CACHE, WAIT_ACCEPT.
- IDLE: on valid_operation_i & cache_ctrl_load_idle_i:
  - cache_ctrl_read_o=1 combinationally in the same cycle.
  - Latch address, operation, packet; data_cachable_o <= !(UNCACHED_START<=addr<=UNCACHED_END).
  - Go to WAIT_CACHE.
  - If valid_operation_i is high while cache_ctrl_load_idle_i is low, nothing is latched; the requester holds the op.
- Misalignment: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - No cache request (cache_ctrl_read_o stays 0).
  - Packet latched with exception=1, exception_vector=MISALIGNED_VECTOR; loaded_data_o <= 0.
  - Go directly to WAIT_ACCEPT, so data_valid_o=1 from the next cycle.
- WAIT_CACHE:
  - cache_ctrl_read_o=1 and cache_ctrl_address_o stable until cache_ctrl_data_valid_i.
  - On cache_ctrl_data_valid_i: register the extracted result; next state WAIT_ACCEPT.
- Extraction from cache_ctrl_data_i, lane chosen by addr[1:0]:
  - LB/LBU: byte lane addr[1:0].
  - LH/LHU: halfword addr[1] (0 -> bits 15:0, 1 -> bits 31:16).
  - LW: full word.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- WAIT_ACCEPT:
  - data_valid_o=1; loaded_data_o and instr_packet_o held constant.
  - On data_accepted_i -> IDLE.
  - A new op is accepted no earlier than the following cycle.
- idle_o = (state_NXT == IDLE), so it is high in the acceptance cycle of data_accepted_i.
- Latency: accept cycle T, cache valid at T+k (k>=1), data_valid_o at T+k+1; minimum 2 cycles accept-to-valid.
- Simultaneous events:
  - valid_operation_i in WAIT_CACHE/WAIT_ACCEPT is ignored (no queue).
  - cache_ctrl_data_valid_i outside WAIT_CACHE is ignored.
- Outputs other than cache_ctrl_read_o, data_valid_o and idle_o are registered.

Test Plan:
- Reset, then LW addr 32'h0000_1000; cache returns 32'hDEAD_BEEF after 3 cycles -> cache_ctrl_read_o high for 4 cycles; cache_ctrl_address_o=32'h0000_1000; data_valid_o next cycle with loaded_data_o=32'hDEAD_BEEF; data_cachable_o=1; exception=0.
- LB addr 32'h0000_2003, cache word 32'h80FF_0011 -> loaded_data_o=32'hFFFF_FF80; same with LBU -> 32'h0000_0080.
- LH addr 32'h0000_9002 (uncached), cache word 32'h7FFF_1234 -> data_cachable_o=0; loaded_data_o=32'h0000_7FFF; LHU addr ...9000 -> 32'h0000_1234.
- LW addr 32'h0000_1002 -> no cache_ctrl_read_o; data_valid_o next cycle; exception=1, exception_vector=4; loaded_data_o=0.
- Hold data_accepted_i low 5 cycles in WAIT_ACCEPT while toggling valid_operation_i and cache_ctrl_data_valid_i -> outputs stable, no new request; accept -> idle_o=1 that cycle, next op accepted the cycle after.
- Assert rst_n_i=0 one cycle while in WAIT_CACHE, then pulse cache_ctrl_data_valid_i -> state IDLE, data_valid_o never asserts, all outputs at reset values.
